zbt_arbiter: RTL and testbench

ZBT_ARBITER -- requirements
Module: zbt_arbiter

---
 rtl/zbt_arbiter.sv | 85 ++++++++
 tb/tb_zbt_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/zbt_arbiter.sv
// zbt_arbiter: single-port ZBT SRAM arbiter between a recorder (writes) and a transmitter (reads)
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-low reset
//   wr_req/addr/data write request, held until wr_ack; wr_ack pulses in the issue cycle
//   rd_req/addr      read request, held until rd_ack; rd_ack pulses in the issue cycle
//   rd_data/rd_valid read data returned RD_LAT cycles after the issue cycle
//   zbt_addr/wdata/we/rdata  ZBT SRAM pins
//   memory_full/memory_empty fill-level decodes of the buffered word count
module zbt_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 36,
  parameter int RD_LAT = 2,
  parameter int DEPTH  = 2**19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] zbt_addr,
  output logic [DATA_W-1:0] zbt_wdata,
  output logic              zbt_we,
  input  logic [DATA_W-1:0] zbt_rdata,
  output logic              memory_full,
  output logic              memory_empty
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  state_t            state_q, state_d;
  logic              last_rd_q;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [RD_LAT-1:0] pipe_q;
  logic [RD_LAT:0]   rd_vec;
  logic              wr_elig, rd_elig;
  assign memory_full  = fill_q == CNT_W'(DEPTH);
  assign memory_empty = fill_q == '0;
  // The port being acknowledged this cycle is still holding its request, so it sits out one cycle
  assign wr_elig = wr_req && !memory_full && state_q != WR;
  assign rd_elig = rd_req && !memory_empty && state_q != RD;
  // Count is committed at selection so full/empty already account for the operation in flight
  always_comb begin
    state_d = (wr_elig && (!rd_elig || last_rd_q)) ? WR : rd_elig ? RD : IDLE;
    fill_d  = state_d == WR ? fill_q + CNT_W'(1) : state_d == RD ? fill_q - CNT_W'(1) : fill_q;
  end
  // rd_vec[0] is the read issue cycle; bit k is k cycles later
  assign rd_vec    = {pipe_q, state_q == RD};
  assign rd_valid  = rd_vec[RD_LAT];
  assign rd_data   = rdata_q;
  assign wr_ack    = state_q == WR;
  assign rd_ack    = state_q == RD;
  assign zbt_we    = state_q == WR;
  assign zbt_addr  = addr_q;
  assign zbt_wdata = wdata_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      last_rd_q <= 1'b1;
      fill_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      pipe_q    <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      pipe_q  <= rd_vec[RD_LAT-1:0];
      if (state_d != IDLE) last_rd_q <= state_d == RD;
      if (state_d == WR) begin
        addr_q  <= wr_addr;
        wdata_q <= wr_data;
      end else if (state_d == RD) begin
        addr_q <= rd_addr;
      end
      if (rd_vec[RD_LAT-1]) rdata_q <= zbt_rdata;
    end
  end
endmodule

// File: tb/tb_zbt_arbiter.sv
// tb_zbt_arbiter: randomized scoreboard bench for zbt_arbiter with a ZBT memory model
module tb_zbt_arbiter;
  localparam int AW = 19, DW = 36, RL = 2, DEPTH = 8;
  logic clk = 0, reset = 0, wr_req = 0, rd_req = 0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0, zbt_rdata = '0;
  logic wr_ack, rd_ack, rd_valid, zbt_we, memory_full, memory_empty;
  logic [DW-1:0] rd_data, zbt_wdata;
  logic [AW-1:0] zbt_addr;
  always #5 clk = ~clk;
  zbt_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .zbt_addr(zbt_addr), .zbt_wdata(zbt_wdata), .zbt_we(zbt_we), .zbt_rdata(zbt_rdata),
    .memory_full(memory_full), .memory_empty(memory_empty)
  );
  int n_chk = 0, n_fail = 0, cyc = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return {a[16:0], ~a};
  endfunction
  // Scoreboard queues: issued requests, expected read data, expected rd_valid cycles
  logic [AW-1:0] wq_a[$], rq_a[$];
  logic [DW-1:0] wq_d[$], dq[$];
  int rvq[$];
  logic [DW-1:0] refmem[logic [AW-1:0]];
  logic [DW-1:0] zmem[logic [AW-1:0]];
  // Reference model state: predicted operation this cycle (0 idle, 1 write, 2 read)
  int p_op, m_fill, n_op;
  bit m_last_rd, ew, er, exp_rv;
  logic [AW-1:0] m_addr, ra;
  logic [DW-1:0] m_wdata, m_rdata;
  bit rpend;
  // ZBT model: data of a read issued in cycle t is presented throughout cycle t+1
  initial forever begin
    @(negedge clk);
    if (zbt_we) zmem[zbt_addr] = zbt_wdata;
    rpend = rd_ack;
    ra = zbt_addr;
    @(posedge clk);
    #1;
    zbt_rdata = rpend ? (zmem.exists(ra) ? zmem[ra] : dflt(ra)) : DW'({$urandom(), $urandom()});
  end
  // Monitor: compares the DUT against the model once per cycle, away from the clock edge
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!reset) begin
      p_op = 0; m_fill = 0; m_last_rd = 1; m_addr = '0; m_wdata = '0; m_rdata = '0;
      wq_a.delete(); wq_d.delete(); rq_a.delete(); dq.delete(); rvq.delete();
    end
    chk("wr_ack", wr_ack, p_op == 1);
    chk("rd_ack", rd_ack, p_op == 2);
    chk("zbt_we", zbt_we, p_op == 1);
    chk("one_op", wr_ack && rd_ack, 0);
    if (wr_ack) begin
      if (wq_a.size() == 0) chk("wr_queue_empty", 0, 1);
      else begin
        m_addr = wq_a.pop_front();
        m_wdata = wq_d.pop_front();
        refmem[m_addr] = m_wdata;
      end
    end
    if (rd_ack) begin
      if (rq_a.size() == 0) chk("rd_queue_empty", 0, 1);
      else begin
        m_addr = rq_a.pop_front();
        dq.push_back(refmem.exists(m_addr) ? refmem[m_addr] : dflt(m_addr));
        rvq.push_back(cyc + RL);
      end
    end
    chk("zbt_addr", zbt_addr, m_addr);
    chk("zbt_wdata", zbt_wdata, m_wdata);
    exp_rv = rvq.size() > 0 && rvq[0] == cyc;
    if (exp_rv) void'(rvq.pop_front());
    chk("rd_valid", rd_valid, exp_rv);
    if (rd_valid) begin
      if (dq.size() == 0) chk("rd_data_queue_empty", 0, 1);
      else m_rdata = dq.pop_front();
    end
    chk("rd_data", rd_data, m_rdata);
    chk("memory_full", memory_full, m_fill == DEPTH);
    chk("memory_empty", memory_empty, m_fill == 0);
    if (reset) begin
      ew = wr_req && m_fill < DEPTH && p_op != 1;
      er = rd_req && m_fill > 0 && p_op != 2;
      n_op = (ew && er) ? (m_last_rd ? 1 : 2) : ew ? 1 : er ? 2 : 0;
      if (n_op == 1) begin m_fill++; m_last_rd = 0; end
      if (n_op == 2) begin m_fill--; m_last_rd = 1; end
      p_op = n_op;
    end
  end
  task automatic issue_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr = a; wr_data = d; wr_req = 1;
    wq_a.push_back(a); wq_d.push_back(d);
  endtask
  task automatic issue_rd(input logic [AW-1:0] a);
    rd_addr = a; rd_req = 1;
    rq_a.push_back(a);
  endtask
  task automatic wait_ack(input bit is_wr);
    bit ok = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(posedge clk);
      #1;
      ok = is_wr ? wr_ack : rd_ack;
    end
    chk(is_wr ? "wr_ack_timeout" : "rd_ack_timeout", ok, 1);
  endtask
  task automatic run(input int cycles, input int pw, input int pr);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (!wr_req || wr_ack) begin
        if ($urandom_range(99) < pw) issue_wr(AW'($urandom_range(0, 15)), DW'({$urandom(), $urandom()}));
        else wr_req = 0;
      end
      if (!rd_req || rd_ack) begin
        if ($urandom_range(99) < pr) issue_rd(AW'($urandom_range(0, 15)));
        else rd_req = 0;
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1;
    // Single write followed by a read of the same word
    issue_wr(19'h00010, 36'h123456789);
    wait_ack(1);
    wr_req = 0;
    chk("dir_we", zbt_we, 1);
    chk("dir_wr_addr", zbt_addr, 19'h00010);
    chk("dir_wr_data", zbt_wdata, 36'h123456789);
    chk("dir_not_empty", memory_empty, 0);
    issue_rd(19'h00010);
    wait_ack(0);
    rd_req = 0;
    chk("dir_rd_addr", zbt_addr, 19'h00010);
    @(posedge clk); #1;
    chk("dir_rd_valid_early", rd_valid, 0);
    @(posedge clk); #1;
    chk("dir_rd_valid", rd_valid, 1);
    chk("dir_rd_data", rd_data, 36'h123456789);
    // Read against an empty buffer waits for a write
    issue_rd(19'h00005);
    repeat (4) begin
      @(posedge clk); #1;
      chk("empty_no_rd_ack", rd_ack, 0);
      chk("empty_no_we", zbt_we, 0);
    end
    issue_wr(19'h00005, 36'h0FEDCBA98);
    wait_ack(1);
    wr_req = 0;
    wait_ack(0);
    rd_req = 0;
    repeat (4) @(posedge clk);
    #1;
    // Reset one cycle after a read issue cancels its rd_valid
    issue_wr(19'h00020, 36'h555555555);
    wait_ack(1);
    wr_req = 0;
    issue_rd(19'h00020);
    wait_ack(0);
    rd_req = 0;
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_zbt_addr", zbt_addr, 0);
    chk("rst_rd_data", rd_data, 0);
    @(posedge clk); #1;
    reset = 1;
    // Randomized phases: fill to full, contention, drain to empty, mixed traffic
    run(60, 100, 0);
    run(80, 100, 100);
    run(100, 15, 100);
    run(300, 70, 70);
    run(100, 100, 100);
    for (int n = 0; n < 100 && (wr_req || rd_req); n++) begin
      @(posedge clk); #1;
      if (wr_ack) wr_req = 0;
      if (rd_ack) rd_req = 0;
    end
    chk("drain_wr", wr_req, 0);
    chk("drain_rd", rd_req, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("left_wr", wq_a.size(), 0);
    chk("left_rd", rq_a.size(), 0);
    chk("left_rdata", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
